// File: rtl/bp_vcache_refill_ctrl_if.sv
// rtl/bp_vcache_refill_ctrl_if.sv - victim-cache hit intake, UCE interlock and D$ write port bundle
interface bp_vcache_refill_ctrl_if #(
  parameter int block_width_p = 512,
  parameter int ptag_width_p  = 28,
  parameter int stat_width_p  = 8,
  parameter int sets_p        = 64,
  parameter int assoc_p       = 8,
  parameter int count_width_p = 16
);
  localparam int index_width_lp = $clog2(sets_p);
  localparam int way_width_lp   = $clog2(assoc_p);

  // victim cache side
  logic                      vc_hit_v_i;
  logic                      vc_hit_ready_o;
  logic [block_width_p-1:0]  vc_data_i;
  logic [ptag_width_p-1:0]   vc_tag_i;
  logic [stat_width_p-1:0]   vc_stat_i;
  logic [index_width_lp-1:0] vc_index_i;
  logic [way_width_lp-1:0]   vc_way_i;
  logic                      vc_remove_o;

  // UCE interlock and flush
  logic                      uce_busy_i;
  logic                      uce_hold_o;
  logic                      flush_i;

  // D$ write port
  logic                      wr_v_o;
  logic [1:0]                wr_sel_o;
  logic [index_width_lp-1:0] wr_index_o;
  logic [way_width_lp-1:0]   wr_way_o;
  logic [block_width_p-1:0]  wr_data_o;
  logic                      wr_yumi_i;

  // status
  logic                      complete_o;
  logic [count_width_p-1:0]  refill_count_o;

  modport slave (
    input  vc_hit_v_i, vc_data_i, vc_tag_i, vc_stat_i, vc_index_i, vc_way_i,
    input  uce_busy_i, flush_i, wr_yumi_i,
    output vc_hit_ready_o, vc_remove_o, uce_hold_o,
    output wr_v_o, wr_sel_o, wr_index_o, wr_way_o, wr_data_o,
    output complete_o, refill_count_o
  );

  modport master (
    output vc_hit_v_i, vc_data_i, vc_tag_i, vc_stat_i, vc_index_i, vc_way_i,
    output uce_busy_i, flush_i, wr_yumi_i,
    input  vc_hit_ready_o, vc_remove_o, uce_hold_o,
    input  wr_v_o, wr_sel_o, wr_index_o, wr_way_o, wr_data_o,
    input  complete_o, refill_count_o
  );
endinterface

// File: rtl/bp_vcache_refill_ctrl.sv
// rtl/bp_vcache_refill_ctrl.sv - replays a victim-cache hit into the D$ as data, tag, stat writes
module bp_vcache_refill_ctrl #(
  parameter int block_width_p = 512,
  parameter int ptag_width_p  = 28,
  parameter int stat_width_p  = 8,
  parameter int sets_p        = 64,
  parameter int assoc_p       = 8,
  parameter int count_width_p = 16
) (
  input logic                   clk_i,
  input logic                   reset_i,
  bp_vcache_refill_ctrl_if.slave bus
);
  localparam int index_width_lp = $clog2(sets_p);
  localparam int way_width_lp   = $clog2(assoc_p);

  typedef enum logic [2:0] {IDLE, DATA, TAG, STAT, DONE} state_e;

  state_e                    state_q, state_d;
  logic [block_width_p-1:0]  data_q;
  logic [ptag_width_p-1:0]   tag_q;
  logic [stat_width_p-1:0]   stat_q;
  logic [index_width_lp-1:0] index_q;
  logic [way_width_lp-1:0]   way_q;
  logic [count_width_p-1:0]  count_q;

  logic ready;
  logic accept;

  // Ready only when idle and nobody else owns or is flushing the fill ports
  assign ready  = (state_q == IDLE) & ~bus.uce_busy_i & ~bus.flush_i;
  assign accept = bus.vc_hit_v_i & ready;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Hit payload capture on accept
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q  <= '0;
      tag_q   <= '0;
      stat_q  <= '0;
      index_q <= '0;
      way_q   <= '0;
    end else if (accept) begin
      data_q  <= bus.vc_data_i;
      tag_q   <= bus.vc_tag_i;
      stat_q  <= bus.vc_stat_i;
      index_q <= bus.vc_index_i;
      way_q   <= bus.vc_way_i;
    end
  end

  // Serviced-refill counter; an aborted DONE does not count
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                                count_q <= '0;
    else if (state_q == DONE && !bus.flush_i)   count_q <= count_q + 1'b1;
  end

  // Next state: each write advances only on yumi, flush aborts any active state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = DATA;
      DATA: if (bus.flush_i) state_d = IDLE; else if (bus.wr_yumi_i) state_d = TAG;
      TAG:  if (bus.flush_i) state_d = IDLE; else if (bus.wr_yumi_i) state_d = STAT;
      STAT: if (bus.flush_i) state_d = IDLE; else if (bus.wr_yumi_i) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: write payload held from registers so it cannot change while waiting for yumi
  always_comb begin
    bus.wr_v_o     = 1'b0;
    bus.wr_sel_o   = 2'd0;
    bus.wr_index_o = '0;
    bus.wr_way_o   = '0;
    bus.wr_data_o  = '0;
    bus.complete_o = 1'b0;
    case (state_q)
      DATA: begin
        bus.wr_v_o    = 1'b1;
        bus.wr_sel_o  = 2'd0;
        bus.wr_data_o = data_q;
      end
      TAG: begin
        bus.wr_v_o    = 1'b1;
        bus.wr_sel_o  = 2'd1;
        bus.wr_data_o = block_width_p'(tag_q);
      end
      STAT: begin
        bus.wr_v_o    = 1'b1;
        bus.wr_sel_o  = 2'd2;
        bus.wr_data_o = block_width_p'(stat_q);
      end
      DONE: bus.complete_o = ~bus.flush_i;
      default: ;
    endcase
    if (bus.wr_v_o) begin
      bus.wr_index_o = index_q;
      bus.wr_way_o   = way_q;
    end
  end

  // Hold covers the accept cycle so the UCE cannot start on the same edge
  assign bus.vc_hit_ready_o = ready;
  assign bus.vc_remove_o    = accept;
  assign bus.uce_hold_o     = (state_q != IDLE) | accept;
  assign bus.refill_count_o = count_q;
endmodule

// File: tb/tb_bp_vcache_refill_ctrl.sv
// tb/tb_bp_vcache_refill_ctrl.sv - scoreboard bench for the victim-cache refill controller
module tb_bp_vcache_refill_ctrl;
  localparam int BW = 512, PW = 28, SW = 8, SETS = 64, ASSOC = 8, CW = 2;

  typedef struct {
    logic [1:0]    sel;
    logic [5:0]    index;
    logic [2:0]    way;
    logic [BW-1:0] data;
  } exp_wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_vcache_refill_ctrl_if #(.block_width_p(BW), .ptag_width_p(PW), .stat_width_p(SW),
                             .sets_p(SETS), .assoc_p(ASSOC), .count_width_p(CW)) bus ();

  bp_vcache_refill_ctrl #(.block_width_p(BW), .ptag_width_p(PW), .stat_width_p(SW),
                          .sets_p(SETS), .assoc_p(ASSOC), .count_width_p(CW))
    dut (.clk_i(clk), .reset_i(rst), .bus(bus));

  exp_wr_t       exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_count = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs, then retire any consumed write against the scoreboard
  task automatic sample();
    exp_wr_t e;
    #1;
    if (bus.wr_v_o === 1'b1 && bus.wr_yumi_i === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write got sel=%0d required no write", bus.wr_sel_o);
      end else begin
        e = exp_q.pop_front();
        if (bus.wr_sel_o !== e.sel || bus.wr_index_o !== e.index ||
            bus.wr_way_o !== e.way || bus.wr_data_o !== e.data) begin
          errors++;
          $display("FAIL sb_write got sel=%0d idx=%0d way=%0d data=%h required sel=%0d idx=%0d way=%0d data=%h",
                   bus.wr_sel_o, bus.wr_index_o, bus.wr_way_o, bus.wr_data_o,
                   e.sel, e.index, e.way, e.data);
        end
      end
    end
  endtask

  task automatic drive_hit(input logic [BW-1:0] d, input logic [PW-1:0] t,
                           input logic [SW-1:0] s, input logic [5:0] idx, input logic [2:0] w);
    bus.vc_hit_v_i = 1'b1;
    bus.vc_data_i  = d;
    bus.vc_tag_i   = t;
    bus.vc_stat_i  = s;
    bus.vc_index_i = idx;
    bus.vc_way_i   = w;
    exp_q.push_back('{sel: 2'd0, index: idx, way: w, data: d});
    exp_q.push_back('{sel: 2'd1, index: idx, way: w, data: BW'(t)});
    exp_q.push_back('{sel: 2'd2, index: idx, way: w, data: BW'(s)});
  endtask

  // Full refill with yumi held high; returns cycles from accept to complete_o
  task automatic do_refill(input logic [BW-1:0] d, input logic [PW-1:0] t,
                           input logic [SW-1:0] s, input logic [5:0] idx, input logic [2:0] w,
                           output int lat);
    tick();
    bus.wr_yumi_i = 1'b1;
    drive_hit(d, t, s, idx, w);
    sample();
    checks++;
    if (bus.vc_remove_o !== 1'b1) begin
      errors++;
      $display("FAIL refill_accept got remove=%b required 1", bus.vc_remove_o);
    end
    tick();
    bus.vc_hit_v_i = 1'b0;
    sample();
    lat = 1;
    while (bus.complete_o !== 1'b1 && lat < 20) begin
      tick();
      sample();
      lat++;
    end
    if (bus.complete_o === 1'b1) exp_count = exp_count + 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.wr_v_o !== 1'b0 || bus.refill_count_o !== '0 || bus.complete_o !== 1'b0 ||
        bus.vc_remove_o !== 1'b0 || bus.uce_hold_o !== 1'b0 || bus.vc_hit_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs got wr_v=%b cnt=%0d cmp=%b rm=%b hold=%b rdy=%b required 0 0 0 0 0 1",
               bus.wr_v_o, bus.refill_count_o, bus.complete_o, bus.vc_remove_o,
               bus.uce_hold_o, bus.vc_hit_ready_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_data();
    tick();
    drive_hit({BW/8{8'h11}}, 28'h1, 8'h1, 6'd1, 3'd1);
    bus.wr_yumi_i = 1'b0;
    sample();
    tick();
    bus.vc_hit_v_i = 1'b0;
    sample();
    checks++;
    if (bus.wr_v_o !== 1'b1 || bus.wr_sel_o !== 2'd0) begin
      errors++;
      $display("FAIL mid_data_setup got wr_v=%b sel=%0d required 1 0", bus.wr_v_o, bus.wr_sel_o);
    end
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_count = '0;
    checks++;
    if (bus.wr_v_o !== 1'b0 || bus.refill_count_o !== exp_count || bus.uce_hold_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_data got wr_v=%b cnt=%0d hold=%b required 0 0 0",
               bus.wr_v_o, bus.refill_count_o, bus.uce_hold_o);
    end
    tick();
    rst = 1'b0;
    bus.wr_yumi_i = 1'b1;
    sample();
    checks++;
    if (bus.vc_hit_ready_o !== 1'b1 || bus.wr_v_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b wr_v=%b required 1 0", bus.vc_hit_ready_o, bus.wr_v_o);
    end
  endtask

  task automatic test_single();
    int lat;
    do_refill({BW/8{8'hA5}}, 28'h123, 8'h3C, 6'd5, 3'd2, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL single_latency got %0d required 4", lat);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_writes got %0d writes outstanding required 0", exp_q.size());
    end
    tick();
    sample();
    checks++;
    if (bus.refill_count_o !== exp_count || bus.complete_o !== 1'b0 || bus.vc_hit_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL single_after got cnt=%0d cmp=%b rdy=%b required %0d 0 1",
               bus.refill_count_o, bus.complete_o, bus.vc_hit_ready_o, exp_count);
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] tag_ext;
    tag_ext = BW'(28'hBEEF);
    tick();
    bus.wr_yumi_i = 1'b1;
    drive_hit({BW/8{8'h5A}}, 28'hBEEF, 8'h77, 6'd9, 3'd6);
    sample();
    tick();
    bus.vc_hit_v_i = 1'b0;
    sample();
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.wr_yumi_i = (i == 3);
      sample();
      checks++;
      if (bus.wr_v_o !== 1'b1 || bus.wr_sel_o !== 2'd1 || bus.wr_data_o !== tag_ext ||
          bus.wr_index_o !== 6'd9 || bus.wr_way_o !== 3'd6) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d got v=%b sel=%0d idx=%0d way=%0d required 1 1 9 6",
                 i, bus.wr_v_o, bus.wr_sel_o, bus.wr_index_o, bus.wr_way_o);
      end
    end
    tick();
    bus.wr_yumi_i = 1'b1;
    sample();
    tick();
    sample();
    checks++;
    if (bus.complete_o !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_complete got %b at N+7 required 1", bus.complete_o);
    end else exp_count = exp_count + 1'b1;
  endtask

  task automatic test_interlock();
    int lat;
    tick();
    bus.uce_busy_i = 1'b1;
    bus.vc_hit_v_i = 1'b1;
    bus.vc_data_i  = {BW/8{8'hFF}};
    sample();
    checks++;
    if (bus.vc_hit_ready_o !== 1'b0 || bus.vc_remove_o !== 1'b0 || bus.uce_hold_o !== 1'b0) begin
      errors++;
      $display("FAIL interlock_block got rdy=%b rm=%b hold=%b required 0 0 0",
               bus.vc_hit_ready_o, bus.vc_remove_o, bus.uce_hold_o);
    end
    tick();
    sample();
    checks++;
    if (bus.wr_v_o !== 1'b0) begin
      errors++;
      $display("FAIL interlock_no_capture got wr_v=%b required 0", bus.wr_v_o);
    end
    tick();
    bus.uce_busy_i = 1'b0;
    drive_hit({BW/8{8'h3C}}, 28'hABCDE, 8'h81, 6'd63, 3'd7);
    sample();
    checks++;
    if (bus.vc_remove_o !== 1'b1 || bus.uce_hold_o !== 1'b1) begin
      errors++;
      $display("FAIL interlock_accept got rm=%b hold=%b required 1 1", bus.vc_remove_o, bus.uce_hold_o);
    end
    tick();
    bus.vc_hit_v_i = 1'b0;
    lat = 1;
    sample();
    while (bus.complete_o !== 1'b1 && lat < 20) begin
      checks++;
      if (bus.uce_hold_o !== 1'b1) begin
        errors++;
        $display("FAIL interlock_hold cycle %0d got %b required 1", lat, bus.uce_hold_o);
      end
      tick();
      bus.uce_busy_i = (lat == 2);
      sample();
      lat++;
    end
    checks++;
    if (lat !== 4 || bus.uce_hold_o !== 1'b1) begin
      errors++;
      $display("FAIL interlock_done got lat=%0d hold=%b required 4 1", lat, bus.uce_hold_o);
    end else exp_count = exp_count + 1'b1;
    tick();
    bus.uce_busy_i = 1'b0;
    sample();
    checks++;
    if (bus.uce_hold_o !== 1'b0 || bus.refill_count_o !== exp_count) begin
      errors++;
      $display("FAIL interlock_release got hold=%b cnt=%0d required 0 %0d",
               bus.uce_hold_o, bus.refill_count_o, exp_count);
    end
  endtask

  task automatic test_flush();
    tick();
    bus.flush_i = 1'b1;
    bus.vc_hit_v_i = 1'b1;
    sample();
    checks++;
    if (bus.vc_hit_ready_o !== 1'b0 || bus.vc_remove_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_block got rdy=%b rm=%b required 0 0", bus.vc_hit_ready_o, bus.vc_remove_o);
    end
    tick();
    bus.flush_i = 1'b0;
    drive_hit({BW/8{8'hC3}}, 28'h0FEDCBA, 8'hE1, 6'd33, 3'd4);
    sample();
    tick();
    bus.vc_hit_v_i = 1'b0;
    sample();
    tick();
    sample();
    tick();
    bus.flush_i = 1'b1;
    sample();
    checks++;
    if (bus.wr_sel_o !== 2'd2 || bus.complete_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_stat got sel=%0d cmp=%b required 2 0", bus.wr_sel_o, bus.complete_o);
    end
    tick();
    bus.flush_i = 1'b0;
    sample();
    checks++;
    if (bus.wr_v_o !== 1'b0 || bus.complete_o !== 1'b0 || bus.vc_hit_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_abort got wr_v=%b cmp=%b rdy=%b required 0 0 1",
               bus.wr_v_o, bus.complete_o, bus.vc_hit_ready_o);
    end
    tick();
    sample();
    checks++;
    if (bus.refill_count_o !== exp_count || bus.complete_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_count got cnt=%0d cmp=%b required %0d 0",
               bus.refill_count_o, bus.complete_o, exp_count);
    end
  endtask

  task automatic test_counter_wrap();
    int lat;
    logic [BW-1:0] d;
    tick();
    rst = 1'b1;
    #1;
    exp_count = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {16{$urandom()}};
      do_refill(d, PW'($urandom()), SW'($urandom()), 6'($urandom_range(0, 63)),
                3'($urandom_range(0, 7)), lat);
      tick();
      sample();
      checks++;
      if (bus.refill_count_o !== exp_count || lat !== 4) begin
        errors++;
        $display("FAIL wrap_count refill %0d got cnt=%0d lat=%0d required %0d 4",
                 i, bus.refill_count_o, lat, exp_count);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.vc_hit_v_i = 1'b0;
    bus.vc_data_i  = '0;
    bus.vc_tag_i   = '0;
    bus.vc_stat_i  = '0;
    bus.vc_index_i = '0;
    bus.vc_way_i   = '0;
    bus.uce_busy_i = 1'b0;
    bus.flush_i    = 1'b0;
    bus.wr_yumi_i  = 1'b0;
    #12;
    test_reset();
    test_single();
    test_reset_mid_data();
    test_backpressure();
    test_interlock();
    test_flush();
    test_counter_wrap();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d outstanding required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_vcache_refill_ctrl.md
Name: bp_vcache_refill_ctrl

Overview:
Sequences a victim-cache hit back into the D$ arrays. It captures the hit line from the victim cache and serializes three writes to the D$ memories: data, then tag, then stat. It shares the D$ fill ports with the UCE by interlocking against it, signals the miss as complete, and counts serviced refills. It sits between bp_vc_generic and the D$ tag/data/stat packet formatters in the softcore memory-end path.

Parameters:
block_width_p, 512, line width in bits
ptag_width_p, 28, physical tag width
stat_width_p, 8, stat info width; must be <= block_width_p
sets_p, 64, D$ sets; index width = log2(sets_p)
assoc_p, 8, D$ ways; way width = log2(assoc_p)
count_width_p, 16, refill counter width

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
vc_hit_v_i  in  1  victim cache hit for the current D$ miss; payload valid
vc_hit_ready_o  out  1  controller can accept a hit
vc_data_i  in  block_width_p  hit line data
vc_tag_i  in  ptag_width_p  hit line tag
vc_stat_i  in  stat_width_p  hit line stat
vc_index_i  in  log2(sets_p)  D$ set to refill
vc_way_i  in  log2(assoc_p)  D$ victim way to refill
vc_remove_o  out  1  one-cycle pulse; invalidate the hit entry in the victim cache
uce_busy_i  in  1  UCE currently owns the D$ fill ports
uce_hold_o  out  1  UCE must not start a new fill
flush_i  in  1  cache flush/abort
wr_v_o  out  1  D$ write valid
wr_sel_o  out  2  0=data, 1=tag, 2=stat; 3 never driven
wr_index_o  out  log2(sets_p)  write set
wr_way_o  out  log2(assoc_p)  write way
wr_data_o  out  block_width_p  payload; tag or stat zero-extended in the LSBs
wr_yumi_i  in  1  D$ consumed the current write
complete_o  out  1  one-cycle pulse; the miss is serviced
refill_count_o  out  count_width_p  number of completed refills

Behaviour:
- State machine states: IDLE, DATA, TAG, STAT, DONE.
- Reset (asynchronous, any state): state=IDLE, payload registers=0, refill_count_o=0. All outputs 0 except vc_hit_ready_o, which takes its combinational value.
- vc_hit_ready_o = (state==IDLE) & ~uce_busy_i & ~flush_i.
- Accept: vc_hit_v_i & vc_hit_ready_o.
  - Capture data, tag, stat, index and way.
  - vc_remove_o=1 in the same cycle.
  - Next state is DATA.
- uce_hold_o = (state!=IDLE) | (vc_hit_v_i & vc_hit_ready_o). The hold covers the accept cycle, so the UCE cannot grab the ports in the same edge.
- DATA/TAG/STAT:
  - wr_v_o=1, with wr_sel_o=0/1/2 respectively.
  - wr_index_o and wr_way_o come from the captured values.
  - wr_data_o carries the captured data, {0,tag} or {0,stat}.
  - Advance only on wr_yumi_i; otherwise hold all outputs stable (valid-yumi, no retraction).
- In STAT, wr_yumi_i moves the state to DONE.
- DONE (one cycle):
  - complete_o=1.
  - refill_count_o increments, wrapping at 2^count_width_p.
  - Next state is IDLE.
- Minimum latency: accept at cycle N gives writes at N+1, N+2 and N+3 (yumi held high) and complete_o at N+4. A back-to-back accept is possible at N+5.
- flush_i in DATA/TAG/STAT/DONE:
  - Next state is IDLE.
  - No complete_o pulse and no counter increment.
  - A write with wr_yumi_i in the same cycle is considered consumed, but the FSM still aborts.
- flush_i in IDLE blocks acceptance.
- wr_yumi_i when wr_v_o=0 is ignored.
- vc_hit_v_i while not ready is ignored; the requester must hold it.
- uce_busy_i rising while the sequence is active has no effect. The UCE is already held, and assertion-checking its protocol is out of scope.

Test Plan:
- Reset then idle: reset_i=1 mid-DATA -> next cycle state IDLE, wr_v_o=0, refill_count_o=0, vc_hit_ready_o=1 once reset_i=0 (uce_busy_i=0, flush_i=0).
- Single refill, yumi always 1:
  - Stimulus: hit with data=0xA5..A5, tag=0x123, stat=0x3C, index=5, way=2.
  - Response: vc_remove_o at N; writes sel 0/1/2 at N+1..N+3 carrying the data, 0x123 and 0x3C at index 5, way 2; complete_o at N+4; count=1.
- Backpressure: yumi low 3 cycles in TAG -> wr_sel_o=1 and payload held stable 4 cycles; complete_o at N+7.
- UCE interlock:
  - uce_busy_i=1 with vc_hit_v_i=1 -> ready=0, no capture.
  - Drop uce_busy_i -> accept the next cycle, and uce_hold_o=1 from the accept cycle through DONE.
- Flush mid-sequence: flush_i in STAT with yumi=1 -> IDLE next cycle, no complete_o, count unchanged.
- Counter wrap: count_width_p=2, 4 refills -> refill_count_o goes 1,2,3,0.
